line_buffer_win3x3: RTL and testbench
=====================================

LINE_BUFFER_WIN3X3 -- requirements
Module: line_buffer_win3x3

Interface
REQ-001 Parameter: IMG_W, default 8, image width in pixels (legal range 3..1024).
REQ-002 Parameter: IMG_H, default 8, image height in pixels (legal range 3..1024).
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: pix_in  input  8  unsigned pixel, raster order (row-major, left to right).
REQ-006 Port: pix_valid  input  1  pix_in valid this cycle.
REQ-007 Port: pix_ready  output  1  block can accept a pixel this cycle.
REQ-008 Port: in0..in8  output  8 each  3x3 window, row-major: in0 = top-left, in8 = bottom-right.
REQ-009 Port: start  output  1  window valid; drives the conv unit's start input.
REQ-010 Port: win_ready  input  1  downstream accepts the window; tie high for a 1-cycle conv unit.
REQ-011 Port: frame_done  output  1  asserted together with the last window of a frame.

Function
REQ-012 Pixel accept = pix_valid && pix_ready; pix_ready = !start || win_ready (combinational).
REQ-013 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) advance only on accept.
REQ-014 col wraps IMG_W-1 -> 0 and increments row; at row IMG_H-1, col IMG_W-1 both return to 0.
REQ-015 Two line buffers of IMG_W x 8 bits hold rows row-1 and row-2, read and written at index col.
REQ-016 On accept, a 3x3 register window shifts left one column; the new right column = {linebuf2[col], linebuf1[col], pix_in}, top to bottom.
REQ-017 On accept, linebuf2[col] <= linebuf1[col] and linebuf1[col] <= pix_in.
REQ-018 Window emitted (no padding, valid-only) iff the accepted pixel has row >= 2 and col >= 2.
REQ-019 Latency: start rises the cycle after the accepting edge, with in0..in8 registered and stable.
REQ-020 Windows per frame = (IMG_W-2)*(IMG_H-2); no window spans a row boundary.
REQ-021 start && !win_ready: in0..in8, start, frame_done hold; pix_ready = 0; no counter or buffer change.
REQ-022 start && win_ready with a new qualifying accept in the same cycle: next window replaces current, start stays 1.
REQ-023 start && win_ready with no qualifying accept: start, frame_done clear next cycle.
REQ-024 frame_done = 1 only with the window from pixel (IMG_H-1, IMG_W-1); same hold/clear rules as start.
REQ-025 Gaps in pix_valid: no state change; back-to-back frames need no idle cycles.

Reset
REQ-026 Async rst: start = 0, frame_done = 0, in0..in8 = 0, col = 0, row = 0; pix_ready = 1 after rst deasserts.
REQ-027 Line-buffer contents are not reset; stale data is never emitted because of REQ-018.
REQ-028 rst mid-frame abandons the frame; the next accepted pixel is (0,0) of a new frame.

Verification (IMG_W=4, IMG_H=4, win_ready=1 unless stated)
REQ-029 Stream 1..16, one pixel per cycle -> 4 windows. First is {1,2,3,5,6,7,9,10,11}, one cycle after pixel 11. Last is {6,7,8,10,11,12,14,15,16}, with frame_done=1.
REQ-030 Same stream with pix_valid toggling 1/0 -> identical window sequence; start only follows accepts.
REQ-031 win_ready=0 for 3 cycles on the first window -> pix_ready=0 and outputs hold {1,2,3,5,6,7,9,10,11}. After release, the remaining 3 windows are correct.
REQ-032 Assert rst after pixel 7, then stream 101..116 -> first window {101,102,103,105,106,107,109,110,111}, 4 windows total.
REQ-033 Two frames back-to-back (1..16, then 17..32) -> 8 windows, frame_done twice. Window 5 is {17,18,19,21,22,23,25,26,27}.
REQ-034 Drive in0..in8 into the conv unit with all kernel weights = 1 -> outputs 54, 63, 90, 99 for frame 1.

Source files
------------

// File: rtl/line_buffer_win3x3.sv
// rtl/line_buffer_win3x3.sv - raster-order pixel stream to 3x3 sliding window with valid/ready handshake
module line_buffer_win3x3 #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] pix_in,
   input  logic       pix_valid,
   output logic       pix_ready,
   output logic [7:0] in0,
   output logic [7:0] in1,
   output logic [7:0] in2,
   output logic [7:0] in3,
   output logic [7:0] in4,
   output logic [7:0] in5,
   output logic [7:0] in6,
   output logic [7:0] in7,
   output logic [7:0] in8,
   output logic       start,
   input  logic       win_ready,
   output logic       frame_done
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [7:0]    linebuf1 [IMG_W];
   logic [7:0]    linebuf2 [IMG_W];
   logic [7:0]    lb_top;
   logic [7:0]    lb_mid;
   logic          accept;
   logic          col_last;
   logic          row_last;
   logic          qualify;

   // A held window blocks new pixels so the window registers never change under it
   assign pix_ready = !start || win_ready;
   assign accept    = pix_valid && pix_ready;
   assign col_last  = (col == CW'(IMG_W - 1));
   assign row_last  = (row == RW'(IMG_H - 1));
   assign qualify   = (row >= RW'(2)) && (col >= CW'(2));
   assign lb_top    = linebuf2[col];
   assign lb_mid    = linebuf1[col];

   // Raster position of the next pixel to be accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Line buffers keep the two previous rows; contents need no reset since
   // windows are only emitted once both rows have been written in this frame
   always_ff @(posedge clk) begin
      if (accept) begin
         linebuf2[col] <= lb_mid;
         linebuf1[col] <= pix_in;
      end
   end

   // Shift the 3x3 window left and load the new right column top to bottom
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in0 <= '0; in1 <= '0; in2 <= '0;
         in3 <= '0; in4 <= '0; in5 <= '0;
         in6 <= '0; in7 <= '0; in8 <= '0;
      end else if (accept) begin
         in0 <= in1; in1 <= in2; in2 <= lb_top;
         in3 <= in4; in4 <= in5; in5 <= lb_mid;
         in6 <= in7; in7 <= in8; in8 <= pix_in;
      end
   end

   // Window-valid and end-of-frame flags: set by a qualifying accept, held while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start      <= 1'b0;
         frame_done <= 1'b0;
      end else if (accept) begin
         start      <= qualify;
         frame_done <= qualify && row_last && col_last;
      end else if (win_ready) begin
         start      <= 1'b0;
         frame_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_line_buffer_win3x3.sv
// tb/tb_line_buffer_win3x3.sv - scoreboard bench for line_buffer_win3x3 at 4x4
module tb_line_buffer_win3x3;

   localparam int W = 4;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pix_in;
   logic       pix_valid;
   logic       pix_ready;
   logic [7:0] in0, in1, in2, in3, in4, in5, in6, in7, in8;
   logic       start;
   logic       win_ready;
   logic       frame_done;

   line_buffer_win3x3 #(.IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
      .in5(in5), .in6(in6), .in7(in7), .in8(in8),
      .start(start), .win_ready(win_ready), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          errors  = 0;
   logic [71:0] sb [$];
   logic [7:0]  img [H][W];
   int          m_col, m_row;
   logic        exp_start, exp_fd;
   logic        accepted;
   int          n_win, n_fd;
   logic        chk_sum;
   int          sum_idx;
   int          sums [4] = '{54, 63, 90, 99};

   function automatic logic [71:0] dut_win();
      return {in0, in1, in2, in3, in4, in5, in6, in7, in8};
   endfunction

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock: compare at negedge against the model, update the model, step past posedge
   task automatic tick();
      logic acc;
      logic qual;
      int   s;
      @(negedge clk);
      check("start", 72'(start), 72'(exp_start));
      check("frame_done", 72'(frame_done), 72'(exp_fd));
      check("pix_ready", 72'(pix_ready), 72'(!exp_start || win_ready));
      if (exp_start && sb.size() > 0) begin
         check("window", dut_win(), sb[0]);
         if (win_ready) begin
            if (chk_sum && sum_idx < 4) begin
               s = in0 + in1 + in2 + in3 + in4 + in5 + in6 + in7 + in8;
               check("conv_sum", 72'(s), 72'(sums[sum_idx]));
               sum_idx++;
            end
            void'(sb.pop_front());
            n_win++;
            if (exp_fd) n_fd++;
         end
      end
      acc = pix_valid && (!exp_start || win_ready);
      accepted = acc;
      if (acc) begin
         img[m_row][m_col] = pix_in;
         qual = (m_row >= 2) && (m_col >= 2);
         if (qual)
            sb.push_back({img[m_row-2][m_col-2], img[m_row-2][m_col-1], img[m_row-2][m_col],
                          img[m_row-1][m_col-2], img[m_row-1][m_col-1], img[m_row-1][m_col],
                          img[m_row][m_col-2],   img[m_row][m_col-1],   img[m_row][m_col]});
         exp_start = qual;
         exp_fd    = qual && (m_row == H-1) && (m_col == W-1);
         if (m_col == W-1) begin
            m_col = 0;
            m_row = (m_row == H-1) ? 0 : m_row + 1;
         end else begin
            m_col++;
         end
      end else if (win_ready) begin
         exp_start = 1'b0;
         exp_fd    = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_pixel(input int val);
      pix_valid = 1'b1;
      pix_in    = 8'(val);
      accepted  = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (accepted) break;
      end
      check("accept_timeout", 72'(accepted), 72'(1));
   endtask

   task automatic drain();
      pix_valid = 1'b0;
      repeat (3) tick();
   endtask

   // Assert reset mid-cycle to exercise the asynchronous clear, then restart the model
   task automatic do_reset();
      pix_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #2;
      check("rst_window", dut_win(), 72'(0));
      check("rst_start", 72'(start), 72'(0));
      check("rst_frame_done", 72'(frame_done), 72'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_col = 0; m_row = 0;
      exp_start = 1'b0; exp_fd = 1'b0;
      sb.delete();
      #1;
      check("rst_pix_ready", 72'(pix_ready), 72'(1));
   endtask

   task automatic clear_counts();
      n_win = 0; n_fd = 0; sum_idx = 0;
   endtask

   initial begin
      rst = 1'b1; pix_in = '0; pix_valid = 1'b0; win_ready = 1'b1;
      chk_sum = 1'b0;
      exp_start = 1'b0; exp_fd = 1'b0; m_col = 0; m_row = 0;
      clear_counts();
      #12;
      do_reset();

      // Single frame, one pixel per cycle, with conv sums of the four windows
      clear_counts();
      chk_sum = 1'b1;
      for (int p = 1; p <= 11; p++) send_pixel(p);
      check("t1_first_win", dut_win(), {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
      for (int p = 12; p <= 16; p++) send_pixel(p);
      check("t1_last_win", dut_win(), {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16});
      check("t1_last_fd", 72'(frame_done), 72'(1));
      drain();
      chk_sum = 1'b0;
      check("t1_win_count", 72'(n_win), 72'(4));
      check("t1_fd_count", 72'(n_fd), 72'(1));

      // Same frame with gaps in pix_valid
      clear_counts();
      for (int p = 1; p <= 16; p++) begin
         pix_valid = 1'b1; pix_in = 8'(p);
         tick();
         pix_valid = 1'b0; pix_in = 8'hEE;
         tick();
      end
      drain();
      check("t2_win_count", 72'(n_win), 72'(4));
      check("t2_fd_count", 72'(n_fd), 72'(1));

      // Downstream stall on the first window
      clear_counts();
      for (int p = 1; p <= 11; p++) send_pixel(p);
      win_ready = 1'b0;
      pix_valid = 1'b1; pix_in = 8'd12;
      repeat (3) tick();
      check("t3_hold_win", dut_win(), {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
      check("t3_hold_ready", 72'(pix_ready), 72'(0));
      win_ready = 1'b1;
      for (int p = 12; p <= 16; p++) send_pixel(p);
      drain();
      check("t3_win_count", 72'(n_win), 72'(4));

      // Reset mid-frame, then a fresh frame
      for (int p = 1; p <= 7; p++) send_pixel(p);
      do_reset();
      clear_counts();
      for (int p = 101; p <= 111; p++) send_pixel(p);
      check("t4_first_win", dut_win(),
            {8'd101, 8'd102, 8'd103, 8'd105, 8'd106, 8'd107, 8'd109, 8'd110, 8'd111});
      for (int p = 112; p <= 116; p++) send_pixel(p);
      drain();
      check("t4_win_count", 72'(n_win), 72'(4));

      // Two frames back to back
      clear_counts();
      for (int p = 1; p <= 27; p++) send_pixel(p);
      check("t5_win5", dut_win(), {8'd17, 8'd18, 8'd19, 8'd21, 8'd22, 8'd23, 8'd25, 8'd26, 8'd27});
      for (int p = 28; p <= 32; p++) send_pixel(p);
      drain();
      check("t5_win_count", 72'(n_win), 72'(8));
      check("t5_fd_count", 72'(n_fd), 72'(2));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
